ncmem_pkt_buffer: RTL



---
 rtl/ncmem_pkg.sv | 15 +
 rtl/ncmem_flit_fifo.sv | 45 ++++
 rtl/ncmem_pkt_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ncmem_pkg.sv
// Shared constants and FSM state types for the NoC packet buffer.
package ncmem_pkg;

  localparam int NOC_DATA_WIDTH = 64;
  localparam int NOC_LEN_LSB    = 22;
  localparam int NOC_LEN_W      = 8;

  typedef enum logic {IN_HDR,  IN_BODY}  in_state_t;
  typedef enum logic {OUT_HDR, OUT_BODY} out_state_t;

  function automatic logic [NOC_LEN_W-1:0] hdr_len(input logic [NOC_DATA_WIDTH-1:0] flit);
    return flit[NOC_LEN_LSB +: NOC_LEN_W];
  endfunction

endpackage

// File: rtl/ncmem_flit_fifo.sv
// First-word-fall-through flop FIFO; pointers carry one extra wrap bit.
module ncmem_flit_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_rd) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ncmem_pkt_buffer.sv
// Store-and-forward packet buffer: releases a packet only once complete,
// except oversize packets, which cut through and latch a sticky error.
module ncmem_pkt_buffer
  import ncmem_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NOC_DATA_WIDTH-1:0] flit_in_data,
  input  logic                      flit_in_val,
  output logic                      flit_in_rdy,
  output logic [NOC_DATA_WIDTH-1:0] flit_out_data,
  output logic                      flit_out_val,
  input  logic                      flit_out_rdy,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      oversize_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [NOC_DATA_WIDTH:0]   wr_entry;
  logic [NOC_DATA_WIDTH:0]   head;
  logic                      head_ct;
  logic [NOC_DATA_WIDTH-1:0] head_data;
  logic [NOC_LEN_W-1:0]      head_len;
  logic [NOC_LEN_W-1:0]      in_len;
  logic                      in_hdr_ct;

  in_state_t            in_state_q, in_state_d;
  logic [NOC_LEN_W-1:0] in_rem_q, in_rem_d;
  logic                 in_ct_q, in_ct_d;
  out_state_t           out_state_q, out_state_d;
  logic [NOC_LEN_W-1:0] out_rem_q, out_rem_d;
  logic                 out_ct_q, out_ct_d;
  logic [CW-1:0]        pkt_count_q, pkt_count_d;
  logic                 err_q, err_d;
  logic                 cnt_inc;
  logic                 cnt_dec;

  assign in_len    = hdr_len(flit_in_data);
  assign in_hdr_ct = (32'(in_len) + 32'd1) > 32'(DEPTH);
  assign push      = flit_in_val && !fifo_full;
  // Only the header entry carries ct; the output side latches it for the body.
  assign wr_entry  = {(in_state_q == IN_HDR) && in_hdr_ct, flit_in_data};

  ncmem_flit_fifo #(
    .WIDTH (NOC_DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_ct   = head[NOC_DATA_WIDTH];
  assign head_data = head[NOC_DATA_WIDTH-1:0];
  assign head_len  = hdr_len(head_data);

  assign flit_in_rdy   = !fifo_full;
  assign flit_out_data = fifo_empty ? '0 : head_data;
  assign pkt_count     = pkt_count_q;
  assign oversize_err  = err_q;

  always_comb begin
    in_state_d = in_state_q;
    in_rem_d   = in_rem_q;
    in_ct_d    = in_ct_q;
    err_d      = err_q;
    cnt_inc    = 1'b0;
    if (push) begin
      case (in_state_q)
        IN_HDR: begin
          if (in_hdr_ct) err_d = 1'b1;
          if (in_len == '0) begin
            cnt_inc = 1'b1;
          end else begin
            in_rem_d   = in_len;
            in_ct_d    = in_hdr_ct;
            in_state_d = IN_BODY;
          end
        end
        IN_BODY: begin
          in_rem_d = in_rem_q - 1'b1;
          if (in_rem_q == 8'd1) begin
            cnt_inc    = !in_ct_q;
            in_state_d = IN_HDR;
          end
        end
        default: in_state_d = IN_HDR;
      endcase
    end
  end

  always_comb begin
    out_state_d  = out_state_q;
    out_rem_d    = out_rem_q;
    out_ct_d     = out_ct_q;
    cnt_dec      = 1'b0;
    flit_out_val = 1'b0;
    case (out_state_q)
      OUT_HDR:  flit_out_val = !fifo_empty && ((pkt_count_q != '0) || head_ct);
      OUT_BODY: flit_out_val = !fifo_empty;
      default:  flit_out_val = 1'b0;
    endcase
    pop = flit_out_val && flit_out_rdy;
    if (pop) begin
      case (out_state_q)
        OUT_HDR: begin
          if (head_len == '0) begin
            cnt_dec = !head_ct;
          end else begin
            out_rem_d   = head_len;
            out_ct_d    = head_ct;
            out_state_d = OUT_BODY;
          end
        end
        OUT_BODY: begin
          out_rem_d = out_rem_q - 1'b1;
          if (out_rem_q == 8'd1) begin
            cnt_dec     = !out_ct_q;
            out_state_d = OUT_HDR;
          end
        end
        default: out_state_d = OUT_HDR;
      endcase
    end
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (cnt_inc && !cnt_dec)      pkt_count_d = pkt_count_q + {{(CW-1){1'b0}}, 1'b1};
    else if (!cnt_inc && cnt_dec) pkt_count_d = pkt_count_q - {{(CW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_HDR;
      in_rem_q    <= '0;
      in_ct_q     <= 1'b0;
      out_state_q <= OUT_HDR;
      out_rem_q   <= '0;
      out_ct_q    <= 1'b0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      in_rem_q    <= in_rem_d;
      in_ct_q     <= in_ct_d;
      out_state_q <= out_state_d;
      out_rem_q   <= out_rem_d;
      out_ct_q    <= out_ct_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

endmodule
